// File: rtl/mem_stage_sram_pkg.sv
// Shared definitions for the SRAM-backed MEM stage: register widths, SRAM geometry
// and the sram_controller FSM state encodings.
package mem_stage_sram_pkg;

  localparam int LEN_REGISTER    = 32;
  localparam int LEN_REG_ADDRESS = 4;
  localparam int SRAM_DATA_W     = 16;
  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_WORD_W     = 17;

  localparam logic [LEN_REGISTER-1:0] MemBase = 32'd1024;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Word index of a byte address as seen by the 16-bit SRAM pair.
  function automatic logic [SRAM_WORD_W-1:0] word_index(input logic [LEN_REGISTER-1:0] addr);
    return addr[18:2];
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Sequences one 32-bit access as two 16-bit SRAM half-accesses (low then high),
// each held SRAM_WAIT+1 cycles, followed by a single-cycle DONE.
module sram_controller
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [SRAM_WORD_W-1:0]  word_addr,
  input  logic [LEN_REGISTER-1:0] wdata,
  output logic                    ready,
  output logic [LEN_REGISTER-1:0] rdata,
  output logic [SRAM_ADDR_W-1:0]  sram_addr,
  inout  wire  [SRAM_DATA_W-1:0]  sram_dq,
  output logic                    sram_we_n
);

  localparam logic [2:0] WaitLast = 3'(SRAM_WAIT);

  logic [1:0]             state_q, state_d;
  logic [2:0]             wait_q, wait_d;
  logic [SRAM_DATA_W-1:0] lo_q, hi_q;
  logic [SRAM_DATA_W-1:0] wr_half;
  logic                   drive;
  logic                   access, is_read, wait_last;

  assign access    = mem_read | mem_write;
  // A simultaneous read+write request is executed as a write only.
  assign is_read   = mem_read & ~mem_write;
  assign wait_last = (wait_q == WaitLast);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ready     = 1'b0;
    sram_addr = '0;
    sram_we_n = 1'b1;
    wr_half   = '0;
    drive     = 1'b0;
    case (state_q)
      StIdle: begin
        ready = ~access;
        if (access) state_d = StLow;
      end
      StLow: begin
        sram_addr = {word_addr, 1'b0};
        sram_we_n = ~mem_write;
        drive     = mem_write;
        wr_half   = wdata[15:0];
        wait_d    = wait_last ? 3'd0 : wait_q + 3'd1;
        if (wait_last) state_d = StHigh;
      end
      StHigh: begin
        sram_addr = {word_addr, 1'b1};
        sram_we_n = ~mem_write;
        drive     = mem_write;
        wr_half   = wdata[31:16];
        wait_d    = wait_last ? 3'd0 : wait_q + 3'd1;
        if (wait_last) state_d = StDone;
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign sram_dq = drive ? wr_half : {SRAM_DATA_W{1'bz}};
  assign rdata   = {hi_q, lo_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wait_q  <= 3'd0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (is_read && wait_last && state_q == StLow)  lo_q <= sram_dq;
      if (is_read && wait_last && state_q == StHigh) hi_q <= sram_dq;
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage backed by a 16-bit external SRAM, plus the MEM/WB register.
// Build option MEM_ADDR_OFFSET_EN: subtract 1024 so data memory starts at byte 1024.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic                       wb_enable_in,
  input  logic [LEN_REGISTER-1:0]    alu_result_in,
  input  logic [LEN_REGISTER-1:0]    reg_file_out2_in,
  input  logic [LEN_REG_ADDRESS-1:0] dest_reg_in,
  output logic                       ready,
  output logic [SRAM_ADDR_W-1:0]     sram_addr,
  inout  wire  [SRAM_DATA_W-1:0]     sram_dq,
  output logic                       sram_we_n,
  output logic                       wb_enable_out,
  output logic                       mem_read_out,
  output logic [LEN_REGISTER-1:0]    alu_result_out,
  output logic [LEN_REGISTER-1:0]    mem_data_out,
  output logic [LEN_REG_ADDRESS-1:0] dest_reg_out
);

  logic [LEN_REGISTER-1:0] eff_addr;
  logic [LEN_REGISTER-1:0] rdata;
  logic                    unused_eff_addr;

`ifdef MEM_ADDR_OFFSET_EN
  assign eff_addr = alu_result_in - MemBase;
`else
  assign eff_addr = alu_result_in;
`endif

  assign unused_eff_addr = ^{eff_addr[31:19], eff_addr[1:0]};

  sram_controller #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_sram_controller (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read_in),
    .mem_write (mem_write_in),
    .word_addr (word_index(eff_addr)),
    .wdata     (reg_file_out2_in),
    .ready     (ready),
    .rdata     (rdata),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_we_n (sram_we_n)
  );

  // MEM/WB register advances only when the stage completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_enable_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      dest_reg_out   <= '0;
    end else if (ready) begin
      wb_enable_out  <= wb_enable_in;
      mem_read_out   <= mem_read_in;
      alu_result_out <= alu_result_in;
      mem_data_out   <= (mem_read_in && !mem_write_in) ? rdata : '0;
      dest_reg_out   <= dest_reg_in;
    end
  end

endmodule
